// File: rtl/mac_sched_pkg.sv
// mac_sched_pkg: shared types and constants for the mac job scheduler.
//   sched_state_e  scheduler FSM encoding (idle / load / issue / drain)
//   OPERAND_W      mac operand width
//   RESULT_W       mac result width
//   MAX_VEC_LEN    largest job length whose worst-case sum still fits RESULT_W
//   CNT_W          pair counter width, sized for MAX_VEC_LEN
//   rr_dist        round-robin distance of a requester from the one after last_grant
package mac_sched_pkg;

  localparam int unsigned OPERAND_W   = 4;
  localparam int unsigned RESULT_W    = 11;
  localparam int unsigned MAX_VEC_LEN = 9;
  localparam int unsigned CNT_W       = $clog2(MAX_VEC_LEN + 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StIssue = 2'd2,
    StDrain = 2'd3
  } sched_state_e;

  // 0 for the requester right after last_grant, n-1 for last_grant itself.
  function automatic int unsigned rr_dist(input int unsigned idx, input int unsigned last,
                                          input int unsigned n);
    return (idx + n - 1 - last) % n;
  endfunction

endpackage

// File: rtl/mac_rr_arbiter.sv
// mac_rr_arbiter: combinational round-robin arbiter.
// Ports:
//   req         in   NUM_REQ  request bits
//   last_grant  in   IdW      requester served most recently
//   grant       out  NUM_REQ  one-hot grant (all zero when no request)
//   grant_id    out  IdW      encoded index of the granted requester
module mac_rr_arbiter
  import mac_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IdW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdW-1:0]     last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IdW-1:0]     grant_id
);

  int unsigned best_dist;
  logic        found;

  // Pick the set request closest (in wrapping order) to last_grant+1.
  always_comb begin
    best_dist = NUM_REQ;
    found     = 1'b0;
    grant_id  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req[i] && (rr_dist(i, 32'(last_grant), NUM_REQ) < best_dist)) begin
        best_dist = rr_dist(i, 32'(last_grant), NUM_REQ);
        found     = 1'b1;
        grant_id  = IdW'(i);
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      grant[i] = found && (grant_id == IdW'(i));
    end
  end

endmodule

// File: rtl/mac_job_scheduler.sv
// mac_job_scheduler: shares one 4x4->11-bit mac between NUM_REQ requesters, one
// VEC_LEN-pair dot-product job at a time. Round-robin grant, operands buffered
// locally, then burst contiguously into the mac; result returned with owner id.
// Optional feature macro: MAC_SCHED_TIMEOUT_EN (drain watchdog, TIMEOUT_CYC cycles).
// Ports:
//   clk, reset                   clock, async active-low reset
//   req/op_valid/op_a/op_b       requester side (op_a/op_b: 4 bits per requester)
//   op_ready                     pair accepted on op_valid[i] & op_ready[i]
//   rsp_valid/rsp_id/rsp_data    one-cycle result strobe, owner, dot product
//   rsp_err                      watchdog expiry, valid with rsp_valid
//   busy                         scheduler not idle
//   mac_in_a/b, mac_in_valid_a/b registered mac inputs
//   mac_out, mac_out_valid       mac result
module mac_job_scheduler
  import mac_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned VEC_LEN     = 8,
  parameter int unsigned TIMEOUT_CYC = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             op_valid,
  input  logic [OPERAND_W*NUM_REQ-1:0]   op_a,
  input  logic [OPERAND_W*NUM_REQ-1:0]   op_b,
  output logic [NUM_REQ-1:0]             op_ready,
  output logic                           rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]     rsp_id,
  output logic [RESULT_W-1:0]            rsp_data,
  output logic                           rsp_err,
  output logic                           busy,
  output logic [OPERAND_W-1:0]           mac_in_a,
  output logic [OPERAND_W-1:0]           mac_in_b,
  output logic                           mac_in_valid_a,
  output logic                           mac_in_valid_b,
  input  logic [RESULT_W-1:0]            mac_out,
  input  logic                           mac_out_valid
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  sched_state_e         state_q, state_d;
  logic [IdW-1:0]       owner_q, owner_d;
  logic [IdW-1:0]       last_grant_q, last_grant_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [OPERAND_W-1:0] mac_a_q, mac_a_d, mac_b_q, mac_b_d;
  logic                 mac_v_q, mac_v_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [IdW-1:0]       rsp_id_q, rsp_id_d;
  logic [RESULT_W-1:0]  rsp_data_q, rsp_data_d;

  logic [OPERAND_W-1:0] op_buf_a [VEC_LEN];
  logic [OPERAND_W-1:0] op_buf_b [VEC_LEN];

  logic [NUM_REQ-1:0]   grant;
  logic [IdW-1:0]       grant_id;
  logic                 own_valid;
  logic [OPERAND_W-1:0] own_a, own_b;
  logic                 load_hs, load_last, issue_last, drain_done, drain_tmo;
  logic [CNT_W-1:0]     rd_idx;
  logic [OPERAND_W-1:0] rd_a, rd_b;

  mac_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IdW     (IdW)
  ) u_arb (
    .req        (req),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_id   (grant_id)
  );

  // Owner's operand lane.
  always_comb begin
    own_valid = 1'b0;
    own_a     = '0;
    own_b     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IdW'(i)) begin
        own_valid = op_valid[i];
        own_a     = op_a[OPERAND_W*i +: OPERAND_W];
        own_b     = op_b[OPERAND_W*i +: OPERAND_W];
      end
    end
  end

  assign load_hs    = (state_q == StLoad) && own_valid;
  assign load_last  = load_hs && (cnt_q == CNT_W'(VEC_LEN - 1));
  assign issue_last = (state_q == StIssue) && (cnt_q == CNT_W'(VEC_LEN - 1));
  assign drain_done = (state_q == StDrain) && mac_out_valid;

  // The first pair is issued on the final load handshake so the mac sees valid
  // the cycle after the last acceptance; each issue cycle then fetches the next.
  assign rd_idx = (state_q == StLoad) ? '0 : cnt_q + CNT_W'(1);

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int unsigned i = 0; i < VEC_LEN; i++) begin
      if (rd_idx == CNT_W'(i)) begin
        rd_a = op_buf_a[i];
        rd_b = op_buf_b[i];
      end
    end
    // VEC_LEN==1: entry 0 is being written this very cycle.
    if (load_hs && (cnt_q == rd_idx)) begin
      rd_a = own_a;
      rd_b = own_b;
    end
  end

  // Operand buffer, no reset needed.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < VEC_LEN; i++) begin
      if (load_hs && (cnt_q == CNT_W'(i))) begin
        op_buf_a[i] <= own_a;
        op_buf_b[i] <= own_b;
      end
    end
  end

`ifdef MAC_SCHED_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            rsp_err_q, rsp_err_d;

  assign tmo_d     = (state_q == StDrain) ? tmo_q + TmoW'(1) : '0;
  assign drain_tmo = (state_q == StDrain) && !mac_out_valid && (tmo_q == TmoW'(TIMEOUT_CYC - 1));
  assign rsp_err_d = drain_tmo;
  assign rsp_err   = rsp_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      rsp_err_q <= rsp_err_d;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYC;
  assign drain_tmo      = 1'b0;
  assign rsp_err        = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (|grant) state_d = StLoad;
      StLoad:  if (load_last) state_d = StIssue;
      StIssue: if (issue_last) state_d = StDrain;
      StDrain: if (drain_done || drain_tmo) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy     = (state_q != StIdle);
    op_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      op_ready[i] = (state_q == StLoad) && (owner_q == IdW'(i));
    end
  end

  // Datapath next state.
  always_comb begin
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    mac_a_d      = '0;
    mac_b_d      = '0;
    mac_v_d      = 1'b0;
    rsp_valid_d  = 1'b0;
    rsp_id_d     = '0;
    rsp_data_d   = '0;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (|grant) owner_d = grant_id;
      end
      StLoad: begin
        if (load_hs) cnt_d = cnt_q + CNT_W'(1);
        if (load_last) begin
          cnt_d   = '0;
          mac_v_d = 1'b1;
          mac_a_d = rd_a;
          mac_b_d = rd_b;
        end
      end
      StIssue: begin
        if (issue_last) begin
          cnt_d = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          mac_v_d = 1'b1;
          mac_a_d = rd_a;
          mac_b_d = rd_b;
        end
      end
      StDrain: begin
        if (drain_done || drain_tmo) begin
          rsp_valid_d  = 1'b1;
          rsp_id_d     = owner_q;
          rsp_data_d   = drain_done ? mac_out : '0;
          last_grant_d = owner_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q      <= '0;
      last_grant_q <= IdW'(NUM_REQ - 1);
      cnt_q        <= '0;
      mac_a_q      <= '0;
      mac_b_q      <= '0;
      mac_v_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
    end else begin
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      mac_a_q      <= mac_a_d;
      mac_b_q      <= mac_b_d;
      mac_v_q      <= mac_v_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign mac_in_a       = mac_a_q;
  assign mac_in_b       = mac_b_q;
  assign mac_in_valid_a = mac_v_q;
  assign mac_in_valid_b = mac_v_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_id         = rsp_id_q;
  assign rsp_data       = rsp_data_q;

endmodule

// File: tb/tb_mac_job_scheduler.sv
// Bench for mac_job_scheduler with NUM_REQ=2, VEC_LEN=8 and a behavioural mac.
// Define MAC_SCHED_TIMEOUT_EN for both RTL and bench to exercise the watchdog.
module tb_mac_job_scheduler;

  localparam int LIMIT = 300;

  typedef struct {
    int id;
    int data;
    int err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, op_valid, op_ready;
  logic [7:0]  op_a, op_b;
  logic        rsp_valid, rsp_err, busy;
  logic [0:0]  rsp_id;
  logic [10:0] rsp_data;
  logic [3:0]  mac_in_a, mac_in_b;
  logic        mac_in_valid_a, mac_in_valid_b;
  logic [10:0] mac_out;
  logic        mac_out_valid;

  logic       req_v [2];
  logic       ov_v  [2];
  logic [3:0] a_v   [2];
  logic [3:0] b_v   [2];

  assign req      = {req_v[1], req_v[0]};
  assign op_valid = {ov_v[1], ov_v[0]};
  assign op_a     = {a_v[1], a_v[0]};
  assign op_b     = {b_v[1], b_v[0]};

  mac_job_scheduler #(
    .NUM_REQ     (2),
    .VEC_LEN     (8),
    .TIMEOUT_CYC (32)
  ) dut (
    .clk            (clk),
    .reset          (rst_n),
    .req            (req),
    .op_valid       (op_valid),
    .op_a           (op_a),
    .op_b           (op_b),
    .op_ready       (op_ready),
    .rsp_valid      (rsp_valid),
    .rsp_id         (rsp_id),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .busy           (busy),
    .mac_in_a       (mac_in_a),
    .mac_in_b       (mac_in_b),
    .mac_in_valid_a (mac_in_valid_a),
    .mac_in_valid_b (mac_in_valid_b),
    .mac_out        (mac_out),
    .mac_out_valid  (mac_out_valid)
  );

  always #5 clk = ~clk;

  // Behavioural mac: accumulate while both valids high, report on first idle cycle.
  logic [10:0] mac_acc, mac_res, spur_data;
  logic        mac_run, mac_ov, mac_kill, spur_ov;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_acc <= '0;
      mac_res <= '0;
      mac_run <= 1'b0;
      mac_ov  <= 1'b0;
    end else begin
      mac_ov <= 1'b0;
      if (mac_in_valid_a && mac_in_valid_b) begin
        mac_acc <= mac_acc + 11'(mac_in_a) * 11'(mac_in_b);
        mac_run <= 1'b1;
      end else if (mac_run) begin
        mac_res <= mac_acc;
        mac_ov  <= !mac_kill;
        mac_acc <= '0;
        mac_run <= 1'b0;
      end
    end
  end

  assign mac_out       = spur_ov ? spur_data : mac_res;
  assign mac_out_valid = mac_ov | spur_ov;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  int   rsp_seen = 0;
  int   run_len  = 0;
  int   vb_bad   = 0;
  int   bad_rdy  = 0;
  logic allow_short;
  logic watch_nonowner;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int id, input int data, input int err);
    exp_t e;
    e.id   = id;
    e.data = data;
    e.err  = err;
    sb.push_back(e);
  endtask

  // Response monitor / scoreboard.
  always @(negedge clk) begin
    if (rsp_valid) begin
      exp_t e;
      rsp_seen++;
      if (sb.size() == 0) begin
        check("unexpected_rsp", 1, 0);
      end else begin
        e = sb.pop_front();
        check("rsp_id", int'(rsp_id), e.id);
        check("rsp_data", int'(rsp_data), e.data);
        check("rsp_err", int'(rsp_err), e.err);
      end
    end
  end

  // Mac burst monitor: every burst must be VEC_LEN contiguous cycles, valids paired.
  always @(negedge clk) begin
    if (mac_in_valid_a != mac_in_valid_b) vb_bad++;
    if (mac_in_valid_a) begin
      run_len++;
    end else if (run_len > 0) begin
      if (!allow_short) begin
        check("mac_run_len", run_len, 8);
        check("mac_valid_pair", vb_bad, 0);
      end
      run_len = 0;
      vb_bad  = 0;
    end
    if (watch_nonowner && op_ready[1]) bad_rdy++;
  end

  function automatic logic [3:0] pat_a(input int mode, input int i);
    case (mode)
      0:       return 4'd15;
      1:       return 4'(i);
      default: return 4'(i + 1);
    endcase
  endfunction

  function automatic logic [3:0] pat_b(input int mode, input int i);
    case (mode)
      0:       return 4'd15;
      1:       return 4'(i);
      default: return 4'd2;
    endcase
  endfunction

  task automatic send_job(input int id, input int mode, input int gap);
    int n;
    req_v[id] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (gap > 0 && i > 0) begin
        ov_v[id] = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      a_v[id]  = pat_a(mode, i);
      b_v[id]  = pat_b(mode, i);
      ov_v[id] = 1'b1;
      n = 0;
      @(negedge clk);
      while (!op_ready[id] && n < LIMIT) begin
        @(negedge clk);
        n++;
      end
      if (n >= LIMIT) begin
        check("op_ready_timeout", 0, 1);
        break;
      end
      @(posedge clk);
      #1;
      if (i == 0) req_v[id] = 1'b0;
    end
    ov_v[id]  = 1'b0;
    req_v[id] = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, int'(n < LIMIT), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int seen0;
    int n;
    for (int i = 0; i < 2; i++) begin
      req_v[i] = 1'b0;
      ov_v[i]  = 1'b0;
      a_v[i]   = '0;
      b_v[i]   = '0;
    end
    rst_n          = 1'b0;
    mac_kill       = 1'b0;
    spur_ov        = 1'b0;
    spur_data      = '0;
    allow_short    = 1'b0;
    watch_nonowner = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_op_ready", int'(op_ready), 0);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_mac_valid_a", int'(mac_in_valid_a), 0);
    check("rst_mac_valid_b", int'(mac_in_valid_b), 0);
    check("rst_mac_in_a", int'(mac_in_a), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single job on req0, all operands 15.
    watch_nonowner = 1'b1;
    bad_rdy        = 0;
    push(0, 1800, 0);
    send_job(0, 0, 0);
    wait_done("t1");
    check("t1_nonowner_ready", bad_rdy, 0);
    watch_nonowner = 1'b0;

    // Simultaneous requests after reset: req0 first, then req1.
    do_reset();
    push(0, 72, 0);
    push(1, 140, 0);
    fork
      send_job(0, 2, 0);
      send_job(1, 1, 0);
    join
    wait_done("t2a");
    // last_grant is now 1, so req0 wins again.
    push(0, 1800, 0);
    push(1, 72, 0);
    fork
      send_job(0, 0, 0);
      send_job(1, 2, 0);
    join
    wait_done("t2b");

    // req1 with gaps in op_valid; mac burst must still be contiguous.
    push(1, 140, 0);
    send_job(1, 1, 2);
    wait_done("t3");

    // Reset during ISSUE aborts the job silently.
    send_job(0, 0, 0);
    @(posedge clk);
    #2;
    allow_short = 1'b1;
    rst_n       = 1'b0;
    #1;
    check("t4_mac_valid_a", int'(mac_in_valid_a), 0);
    check("t4_mac_valid_b", int'(mac_in_valid_b), 0);
    check("t4_busy", int'(busy), 0);
    seen0 = rsp_seen;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("t4_no_rsp", rsp_seen - seen0, 0);
    allow_short = 1'b0;
    push(0, 1800, 0);
    send_job(0, 0, 0);
    wait_done("t4");

    // Spurious mac_out_valid in IDLE and during LOAD.
    seen0 = rsp_seen;
    spur_data = 11'd555;
    spur_ov   = 1'b1;
    @(posedge clk);
    #1 spur_ov = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t5_idle_no_rsp", rsp_seen - seen0, 0);
    check("t5_idle_op_ready", int'(op_ready), 0);
    watch_nonowner = 1'b1;
    bad_rdy        = 0;
    push(0, 72, 0);
    fork
      send_job(0, 2, 1);
      begin
        n = 0;
        while (!busy && n < LIMIT) begin
          @(posedge clk);
          #1;
          n++;
        end
        repeat (3) @(posedge clk);
        #1 spur_ov = 1'b1;
        @(posedge clk);
        #1 spur_ov = 1'b0;
      end
    join
    wait_done("t5");
    check("t5_nonowner_ready", bad_rdy, 0);
    watch_nonowner = 1'b0;

`ifdef MAC_SCHED_TIMEOUT_EN
    // Mac never reports: watchdog fires after 32 drain cycles.
    mac_kill = 1'b1;
    push(0, 0, 1);
    send_job(0, 0, 0);
    n = 0;
    while (mac_in_valid_a && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!rsp_valid && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("t6_drain_cycles", n, 32);
    wait_done("t6");
    mac_kill = 1'b0;
`endif

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
